// File: rtl/adc_osr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : adc_osr_sequencer
// Purpose  : Triggers SAR conversions, accumulates 2^osr_sel samples per
//            frame, scales the sum to a 16-bit full-scale result and pulses
//            per-sample / per-frame completion strobes. A watchdog aborts a
//            frame when the SAR core never answers.
// Revision : 1.0 - initial release
// ============================================================================
module adc_osr_sequencer #(
  parameter int SAR_W   = 12,
  parameter int RES_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             cont_mode,
  input  logic             start,
  input  logic [2:0]       osr_sel,
  output logic             sar_start,
  input  logic             sar_done,
  input  logic [SAR_W-1:0] sar_data,
  output logic [RES_W-1:0] adc_res,
  output logic             adc_conv_finished,
  output logic             adc_conv_finished_osr,
  output logic             busy,
  output logic             timeout_err
);

  // 128 samples of SAR_W bits need 7 extra bits of headroom
  localparam int ACC_W = SAR_W + 7;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic [ACC_W-1:0] acc;
  logic [7:0]       cnt;
  logic [TMR_W-1:0] timer;
  logic [2:0]       osr_r;
  logic [RES_W-1:0] scaled;
  logic             frame_req;
  logic             last_sample;
  logic             timer_exp;

  assign frame_req   = start | cont_mode;
  assign last_sample = (cnt == ((8'd1 << osr_r) - 8'd1));
  assign timer_exp   = (timer == TMR_W'(TIMEOUT - 1));

  // Normalise the sum to full scale: shift left for small frames, right
  // (truncating) for frames larger than 16 samples
  always_comb begin
    if (osr_r <= 3'd4) begin
      scaled = RES_W'(acc << (3'd4 - osr_r));
    end else begin
      scaled = RES_W'(acc >> (osr_r - 3'd4));
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; dropping enable abandons the frame from any state
  always_comb begin
    next_state = state;
    if (!enable) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (frame_req) next_state = S_START;
        S_START: next_state = S_WAIT;
        S_WAIT: begin
          if (sar_done) begin
            next_state = last_sample ? S_DONE : S_START;
          end else if (timer_exp) begin
            next_state = S_IDLE;
          end
        end
        S_DONE:  next_state = S_IDLE;
        default: next_state = S_IDLE;
      endcase
    end
  end

  // State-decoded outputs
  always_comb begin
    sar_start = (state == S_START);
    busy      = (state != S_IDLE);
  end

  // Datapath: accumulator, sample counter, watchdog timer and result strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      acc                   <= '0;
      cnt                   <= '0;
      timer                 <= '0;
      osr_r                 <= '0;
      adc_res               <= '0;
      adc_conv_finished     <= 1'b0;
      adc_conv_finished_osr <= 1'b0;
      timeout_err           <= 1'b0;
    end else begin
      adc_conv_finished     <= 1'b0;
      adc_conv_finished_osr <= 1'b0;
      if (enable) begin
        case (state)
          S_IDLE: begin
            if (frame_req) begin
              osr_r <= osr_sel;
              acc   <= '0;
              cnt   <= '0;
            end
          end
          S_START: begin
            timer <= '0;
          end
          S_WAIT: begin
            if (sar_done) begin
              acc               <= acc + {{(ACC_W-SAR_W){1'b0}}, sar_data};
              cnt               <= cnt + 8'd1;
              adc_conv_finished <= 1'b1;
            end else if (timer_exp) begin
              timeout_err <= 1'b1;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          S_DONE: begin
            adc_res               <= scaled;
            adc_conv_finished_osr <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adc_osr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_osr_sequencer
// Purpose  : Self-checking bench for adc_osr_sequencer: directed vector table,
//            multi-cycle corner sequences and randomized frames scored
//            against a frame-level arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_osr_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        cont_mode;
  logic        start;
  logic [2:0]  osr_sel;
  logic        sar_start;
  logic        sar_done;
  logic [11:0] sar_data;
  logic [15:0] adc_res;
  logic        adc_conv_finished;
  logic        adc_conv_finished_osr;
  logic        busy;
  logic        timeout_err;

  adc_osr_sequencer #(.SAR_W(12), .RES_W(16), .TIMEOUT(255)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .enable                (enable),
    .cont_mode             (cont_mode),
    .start                 (start),
    .osr_sel               (osr_sel),
    .sar_start             (sar_start),
    .sar_done              (sar_done),
    .sar_data              (sar_data),
    .adc_res               (adc_res),
    .adc_conv_finished     (adc_conv_finished),
    .adc_conv_finished_osr (adc_conv_finished_osr),
    .busy                  (busy),
    .timeout_err           (timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // SAR core emulation state
  bit          respond = 1'b0;
  int          pend    = 0;
  int          dly_lo  = 1;
  int          dly_hi  = 1;
  int          smode   = 0;
  logic [11:0] sval    = '0;
  int          kidx    = 0;
  longint      sum     = 0;

  typedef struct {
    logic [2:0]  osr;
    int          mode;
    logic [11:0] val;
    int          dly;
    logic [15:0] exp_res;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame result from the arithmetic definition: full scale is 16x one sample
  function automatic logic [15:0] model_res(input longint s, input int osr);
    longint t;
    t = (s * 16) >> osr;
    return t[15:0];
  endfunction

  // Advance one clock, then act as the SAR core: answer each sar_start after
  // a delay of dly_lo..dly_hi cycles with a one-cycle sar_done
  task automatic step();
    logic [11:0] v;
    @(posedge clk);
    #1;
    cyc++;
    sar_done = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        case (smode)
          0:       v = sval;
          1:       v = 12'(sval * (kidx + 1));
          default: v = 12'($urandom);
        endcase
        kidx++;
        sar_done = 1'b1;
        sar_data = v;
        sum      = sum + longint'(v);
      end
    end
    if (sar_start && respond) pend = $urandom_range(dly_hi, dly_lo);
  endtask

  task automatic run_frame(input logic [2:0] osr, input int mode, input logic [11:0] val,
                           input int dlo, input int dhi, input bit scramble,
                           output logic [15:0] res, output longint s);
    int nconv;
    int last;
    int guard;
    bit got;
    osr_sel = osr; smode = mode; sval = val; kidx = 0; sum = 0;
    dly_lo = dlo; dly_hi = dhi; respond = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    nconv = 0; last = -100; guard = 0; got = 1'b0; res = '0;
    while (!got && guard < 4000) begin
      if (scramble) osr_sel = 3'($urandom);
      if (adc_conv_finished) begin
        nconv++;
        last = cyc;
      end
      if (adc_conv_finished_osr) begin
        got = 1'b1;
        res = adc_res;
        chk("osr_pulse_latency", cyc - last, 1);
      end else begin
        step();
        guard++;
      end
    end
    chk("frame_done", longint'(got), 1);
    chk("conv_count", nconv, 1 << osr);
    chk("busy_after_frame", longint'(busy), 0);
    s = sum;
  endtask

  initial begin
    logic [15:0] res;
    logic [15:0] prev_res;
    longint      s;
    bit          ok;
    int          nconv;
    int          guard;
    int          nosr;
    int          starts[$];
    logic [2:0]  osr;

    vecs[0] = '{3'd0, 0, 12'hABC, 3, 16'hABC0};
    vecs[1] = '{3'd2, 1, 12'h100, 1, 16'h2800};
    vecs[2] = '{3'd7, 0, 12'hFFF, 1, 16'hFFF0};
    vecs[3] = '{3'd4, 0, 12'h123, 2, 16'h1230};
    vecs[4] = '{3'd5, 0, 12'h001, 1, 16'h0010};
    vecs[5] = '{3'd1, 0, 12'h800, 2, 16'h8000};

    rst = 1'b1; enable = 1'b0; cont_mode = 1'b0; start = 1'b0;
    osr_sel = '0; sar_done = 1'b0; sar_data = '0;
    step();
    step();
    chk("rst_sar_start", longint'(sar_start), 0);
    chk("rst_conv", longint'(adc_conv_finished), 0);
    chk("rst_osr", longint'(adc_conv_finished_osr), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_err", longint'(timeout_err), 0);
    chk("rst_res", longint'(adc_res), 0);
    rst = 1'b0;
    enable = 1'b1;
    step();

    // sar_done while idle must not be taken as a sample
    sar_done = 1'b1;
    sar_data = 12'hFFF;
    step();
    chk("idle_done_ignored", longint'(adc_conv_finished), 0);
    chk("idle_not_busy", longint'(busy), 0);

    // Directed vector table
    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].osr, vecs[i].mode, vecs[i].val, vecs[i].dly, vecs[i].dly, 1'b0, res, s);
      chk("vec_res", longint'(res), longint'(vecs[i].exp_res));
      step();
    end
    prev_res = adc_res;

    // Watchdog: SAR never answers
    respond = 1'b0;
    osr_sel = 3'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("wd_sar_start", longint'(sar_start), 1);
    ok = 1'b1;
    for (int i = 0; i < 255; i++) begin
      step();
      if (!busy || timeout_err || adc_conv_finished_osr) ok = 1'b0;
    end
    chk("wd_wait_255", longint'(ok), 1);
    step();
    chk("wd_idle", longint'(busy), 0);
    chk("wd_err_set", longint'(timeout_err), 1);
    chk("wd_res_held", longint'(adc_res), longint'(prev_res));
    run_frame(3'd0, 0, 12'h555, 1, 1, 1'b0, res, s);
    chk("wd_next_frame", longint'(res), 16'h5550);
    chk("wd_err_sticky", longint'(timeout_err), 1);
    prev_res = adc_res;
    step();

    // Enable dropped after 2 of 4 samples
    osr_sel = 3'd2; smode = 1; sval = 12'h100; kidx = 0; sum = 0;
    dly_lo = 2; dly_hi = 2; respond = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    nconv = 0; guard = 0;
    while (nconv < 2 && guard < 100) begin
      step();
      guard++;
      if (adc_conv_finished) nconv++;
    end
    chk("drop_two_samples", nconv, 2);
    enable = 1'b0;
    step();
    pend = 0;
    sar_done = 1'b0;
    chk("drop_idle", longint'(busy), 0);
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (adc_conv_finished_osr || busy) ok = 1'b0;
    end
    chk("drop_no_osr", longint'(ok), 1);
    chk("drop_res_held", longint'(adc_res), longint'(prev_res));
    enable = 1'b1;
    run_frame(3'd2, 1, 12'h100, 1, 1, 1'b0, res, s);
    chk("drop_fresh_frame", longint'(res), 16'h2800);
    step();

    // Randomized frames with osr_sel scrambled mid-frame
    for (int i = 0; i < 12; i++) begin
      osr = 3'($urandom_range(6, 0));
      run_frame(osr, 2, 12'h000, 1, 4, 1'b1, res, s);
      chk("rand_res", longint'(res), longint'(model_res(s, int'(osr))));
      step();
    end

    // Continuous mode, immediate answers
    osr_sel = 3'd1; smode = 0; sval = 12'h400; kidx = 0; sum = 0;
    dly_lo = 1; dly_hi = 1; respond = 1'b1;
    cont_mode = 1'b1;
    nosr = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (sar_start) starts.push_back(cyc);
      if (adc_conv_finished_osr) begin
        nosr++;
        chk("cont_res", longint'(adc_res), 16'h4000);
      end
    end
    chk("cont_frames", longint'(nosr >= 3), 1);
    for (int i = 1; i < starts.size(); i++) begin
      chk("cont_start_gap", starts[i] - starts[i-1], (i % 2 == 1) ? 2 : 4);
    end

    // Reset injected mid-frame
    guard = 0;
    while (!sar_start && guard < 10) begin
      step();
      guard++;
    end
    rst = 1'b1;
    step();
    pend = 0;
    sar_done = 1'b0;
    chk("mrst_sar_start", longint'(sar_start), 0);
    chk("mrst_busy", longint'(busy), 0);
    chk("mrst_res", longint'(adc_res), 0);
    chk("mrst_err", longint'(timeout_err), 0);
    chk("mrst_conv", longint'(adc_conv_finished), 0);
    chk("mrst_osr", longint'(adc_conv_finished_osr), 0);
    cont_mode = 1'b0;
    rst = 1'b0;
    step();
    chk("post_rst_idle", longint'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
